switches_to_leds: RTL and testbench
===================================

Name: switches_to_leds

Overview:
- Maps four board slide switches/buttons onto four LEDs, one-to-one (switch N drives LED N).
- Each switch input is asynchronous to the fabric clock. Each path is therefore synchronised, then debounced, then driven from a registered output.
- Top-level board glue block: switch pins in, LED pins out.

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive clock cycles a synchronised switch level must differ from the current stable level before it is accepted. Legal range is >= 1. The default is 10 ms at 25 MHz.

Ports:
- i_clk  input  1  fabric clock, all logic on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_switch_1  input  1  switch 1, asynchronous raw level
- i_switch_2  input  1  switch 2, asynchronous raw level
- i_switch_3  input  1  switch 3, asynchronous raw level
- i_switch_4  input  1  switch 4, asynchronous raw level
- o_led_1  output  1  LED 1, 1 = lit
- o_led_2  output  1  LED 2, 1 = lit
- o_led_3  output  1  LED 3, 1 = lit
- o_led_4  output  1  LED 4, 1 = lit

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Four identical, fully independent channels. There is no cross-channel interaction, so simultaneous changes on several switches are handled independently.
- Per channel, the pipeline is:
  - 2-flop synchroniser: sync1 <= raw; sync2 <= sync1.
  - Debouncer: a `stable` register plus a counter of width $clog2(DEBOUNCE_LIMIT+1).
  - Output: o_led_N = the channel's registered output flop.
- Debounce rule, evaluated each rising edge:
  - If sync2 == stable, the counter is cleared to 0.
  - Else, if counter == DEBOUNCE_LIMIT-1: stable <= sync2 and the counter is cleared to 0.
  - Else: the counter increments by 1.
- Glitch rejection: any return of sync2 to the stable value before the limit is reached clears the counter. A bounce therefore restarts the count.
- Latency: a raw level held constant is reflected on o_led_N exactly DEBOUNCE_LIMIT+2 rising edges after it is first sampled by sync1. The output register is the `stable` flop itself in base mode, so there is no extra cycle.
- Pulses shorter than DEBOUNCE_LIMIT cycles, as seen at sync2, never reach the LED.
- Reset, asserted at any time including mid-count:
  - Immediately and asynchronously clears sync1, sync2, stable, the counters and all o_led_N to 0.
  - After release, a switch already high is accepted via the normal path, DEBOUNCE_LIMIT+2 edges later.
- Reset release is assumed synchronised by the integrator. The block adds no reset synchroniser.
- No X propagation: all flops are reset.

Optional Feature:
- Macro: SWITCHES_TO_LEDS_TOGGLE_EN.
- Defined (toggle mode):
  - Each channel has a separate LED flop, reset to 0.
  - The LED flop inverts on the cycle after its `stable` transitions 0->1, i.e. one edge after acceptance.
  - 1->0 transitions of `stable` do not affect the LED.
  - Latency from a raw rising level to the LED change is DEBOUNCE_LIMIT+3 edges.
- Undefined (base mode): o_led_N follows the level of `stable`, as described above.
- Port list and parameters are identical in both modes.

Test Plan:
All scenarios use DEBOUNCE_LIMIT=4, 10 ns clock, and i_rst pulsed high for 2 cycles at start.

1. Reset: all switches 0, or any switch pattern, during reset -> all o_led_N = 0 while i_rst=1. Assert i_rst asynchronously mid-cycle -> outputs go 0 before the next clock edge.
2. Walking one: switches 1000, 0100, 0010, 0001, each held 20 cycles -> LEDs equal 1000, 0100, 0010, 0001 respectively. Each change occurs exactly 6 edges after the switch change, and no other LED toggles.
3. Bounce rejection: i_switch_2 goes high for 3 cycles, low for 1 cycle, then high and held -> o_led_2 stays 0 through the bounce. It rises 6 edges after the final rising level.
4. Short glitch: i_switch_3 high for 2 cycles, then low -> o_led_3 never leaves 0.
5. Simultaneous: all four switches change 0->1 on the same edge -> all LEDs rise on the same edge, 6 edges later. Repeat for 1->0.
6. Reset mid-count: i_switch_4 high; assert i_rst after 3 cycles; release; hold high -> o_led_4 = 0 until 6 edges after release, then 1.
   - Toggle build: two accepted presses of switch 1 -> o_led_1 goes 0->1->0. Each change occurs 7 edges after the press's rising level.

Source files
------------

// File: rtl/switches_to_leds.sv
// -----------------------------------------------------------------------------
// switches_to_leds
//
// Board glue: four slide switches / buttons drive four LEDs one-to-one
// (switch N -> LED N). Every channel is independent and identical:
//
//   raw pin -> 2-flop synchroniser -> debouncer (stable flop + counter) -> LED
//
// A new synchronised level is accepted only after it has differed from the
// current stable level for DEBOUNCE_LIMIT consecutive clock cycles. Any return
// to the stable level before that restarts the count, so bounces and short
// glitches never reach the LED.
//
// Optional build macro: SWITCHES_TO_LEDS_TOGGLE_EN
//   undefined : LED N follows the debounced level of switch N
//               (latency DEBOUNCE_LIMIT+2 edges from first sync1 sample).
//   defined   : LED N is a separate flop that inverts one edge after the
//               debounced level goes 0->1 (latency DEBOUNCE_LIMIT+3 edges);
//               debounced 1->0 transitions leave the LED untouched.
//
// Parameters:
//   DEBOUNCE_LIMIT : accept threshold in clock cycles, >= 1
//                    (default 250000 = 10 ms at 25 MHz)
//
// Ports:
//   i_clk              fabric clock, all logic on the rising edge
//   i_rst              asynchronous active-high reset, clears every flop
//   i_switch_1..4      raw switch levels, asynchronous to i_clk
//   o_led_1..4         LED drive, 1 = lit, straight from a flop
//
// Reset release is expected to be synchronised to i_clk by the integrator.
// -----------------------------------------------------------------------------
`default_nettype none

module switches_to_leds #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch_1,
  input  logic i_switch_2,
  input  logic i_switch_3,
  input  logic i_switch_4,
  output logic o_led_1,
  output logic o_led_2,
  output logic o_led_3,
  output logic o_led_4
);

  localparam int NUM_CH = 4;
  localparam int CNT_W  = $clog2(DEBOUNCE_LIMIT + 1);
  // Terminal count: the cycle on which the counter would reach the limit is
  // the acceptance cycle itself, so compare against LIMIT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] sw_raw;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync1_d;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] sync2_d;
  logic [NUM_CH-1:0] stable_q;
  logic [NUM_CH-1:0] stable_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] led_out;

  assign sw_raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (sync2_q[ch] == stable_q[ch]) begin
        // Level agrees with the accepted one: any partial count was a glitch.
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        stable_d[ch] = sync2_q[ch];
        cnt_d[ch]    = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LED output stage
  // ---------------------------------------------------------------------------
`ifdef SWITCHES_TO_LEDS_TOGGLE_EN
  logic [NUM_CH-1:0] stable_prev_q;
  logic [NUM_CH-1:0] stable_prev_d;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] led_d;

  // stable_prev_q lags stable_q by one edge, so (stable & ~prev) is high for
  // exactly the cycle after a 0->1 acceptance; the LED flips on that edge.
  always_comb begin
    stable_prev_d = stable_q;
    led_d         = led_q ^ (stable_q & ~stable_prev_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stable_prev_q <= '0;
      led_q         <= '0;
    end else begin
      stable_prev_q <= stable_prev_d;
      led_q         <= led_d;
    end
  end

  assign led_out = led_q;
`else
  // Level mode: the stable flop is itself the registered LED driver.
  assign led_out = stable_q;
`endif

  assign o_led_1 = led_out[0];
  assign o_led_2 = led_out[1];
  assign o_led_3 = led_out[2];
  assign o_led_4 = led_out[3];

endmodule

`default_nettype wire

// File: tb/tb_switches_to_leds.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for switches_to_leds with DEBOUNCE_LIMIT = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after a
// rising edge. "Edge k" below is the k-th rising edge after an input change,
// edge 1 being the one where sync1 first samples the new level.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_switches_to_leds;

  localparam int LIMIT = 4;
`ifdef SWITCHES_TO_LEDS_TOGGLE_EN
  localparam int ACC = LIMIT + 3;
`else
  localparam int ACC = LIMIT + 2;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] leds;
  logic       led1, led2, led3, led4;

  int n_checks;
  int n_fail;

  switches_to_leds #(
    .DEBOUNCE_LIMIT(LIMIT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_switch_1(sw[0]),
    .i_switch_2(sw[1]),
    .i_switch_3(sw[2]),
    .i_switch_4(sw[3]),
    .o_led_1   (led1),
    .o_led_2   (led2),
    .o_led_3   (led3),
    .o_led_4   (led4)
  );

  assign leds = {led4, led3, led2, led1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset state, release with switches already high, async assertion.
  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b1;
    sw  = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (leds !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: leds=%b expected 0000", k, leds);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= ACC; k++) begin
      step();
      exp = (k >= ACC) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (leds !== exp) begin
        n_fail++;
        $display("FAIL reset_release edge=%0d: leds=%b expected %b", k, leds, exp);
      end
    end
    // Mid-cycle asynchronous assertion: must clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: leds=%b expected 0000", leds);
    end
    sw = 4'b0000;
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (leds !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle edge=%0d: leds=%b expected 0000", k, leds);
      end
    end
  endtask

`ifdef SWITCHES_TO_LEDS_TOGGLE_EN
  // Two accepted presses of switch 1: LED goes 0 -> 1 -> 0.
  task automatic test_toggle();
    logic exp_led;
    logic cur;
    cur = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sw = 4'b0001;
      for (int k = 1; k <= ACC + 3; k++) begin
        step();
        exp_led = (k >= ACC) ? ~cur : cur;
        n_checks++;
        if (leds !== {3'b000, exp_led}) begin
          n_fail++;
          $display("FAIL toggle_press%0d edge=%0d: leds=%b expected %b",
                   p, k, leds, {3'b000, exp_led});
        end
      end
      cur = ~cur;
      sw = 4'b0000;
      for (int k = 1; k <= ACC + 3; k++) begin
        step();
        n_checks++;
        if (leds !== {3'b000, cur}) begin
          n_fail++;
          $display("FAIL toggle_release%0d edge=%0d: leds=%b expected %b",
                   p, k, leds, {3'b000, cur});
        end
      end
    end
  endtask
`else
  // Walking one through all switches, 20 cycles each.
  task automatic test_walking_one();
    logic [3:0] pats [4];
    logic [3:0] prev;
    logic [3:0] exp;
    pats[0] = 4'b1000;
    pats[1] = 4'b0100;
    pats[2] = 4'b0010;
    pats[3] = 4'b0001;
    prev = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      sw = pats[p];
      for (int k = 1; k <= 20; k++) begin
        step();
        exp = (k >= ACC) ? pats[p] : prev;
        n_checks++;
        if (leds !== exp) begin
          n_fail++;
          $display("FAIL walk pat=%b edge=%0d: leds=%b expected %b",
                   pats[p], k, leds, exp);
        end
      end
      prev = pats[p];
    end
    sw = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k >= ACC) ? 4'b0000 : 4'b0001;
      n_checks++;
      if (leds !== exp) begin
        n_fail++;
        $display("FAIL walk_clear edge=%0d: leds=%b expected %b", k, leds, exp);
      end
    end
  endtask

  // Switch 2: high 3, low 1, then high held. Count restarts on the bounce.
  task automatic test_bounce();
    logic [3:0] exp;
    sw = 4'b0010;
    step();
    step();
    step();
    sw = 4'b0000;
    step();
    sw = 4'b0010;
    // The final rising level is first sampled on this step (edge 1).
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k >= ACC) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (leds !== exp) begin
        n_fail++;
        $display("FAIL bounce edge=%0d: leds=%b expected %b", k, leds, exp);
      end
    end
    sw = 4'b0000;
    for (int k = 1; k <= 8; k++) step();
    n_checks++;
    if (leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL bounce_release: leds=%b expected 0000", leds);
    end
  endtask

  // Switch 3 high for only 2 cycles: never accepted.
  task automatic test_glitch();
    sw = 4'b0100;
    step();
    step();
    sw = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (leds !== 4'b0000) begin
        n_fail++;
        $display("FAIL glitch edge=%0d: leds=%b expected 0000", k, leds);
      end
    end
  endtask

  // All four switches change on the same edge, both directions.
  task automatic test_simultaneous();
    logic [3:0] exp;
    sw = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k >= ACC) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (leds !== exp) begin
        n_fail++;
        $display("FAIL simul_rise edge=%0d: leds=%b expected %b", k, leds, exp);
      end
    end
    sw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k >= ACC) ? 4'b0000 : 4'b1111;
      n_checks++;
      if (leds !== exp) begin
        n_fail++;
        $display("FAIL simul_fall edge=%0d: leds=%b expected %b", k, leds, exp);
      end
    end
  endtask

  // Switch 4 high, reset after 3 cycles, then held high: full restart.
  task automatic test_reset_mid_count();
    logic [3:0] exp;
    sw = 4'b1000;
    step();
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (leds !== 4'b0000) begin
        n_fail++;
        $display("FAIL midrst_hold cyc=%0d: leds=%b expected 0000", k, leds);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = (k >= ACC) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (leds !== exp) begin
        n_fail++;
        $display("FAIL midrst_release edge=%0d: leds=%b expected %b", k, leds, exp);
      end
    end
    sw = 4'b0000;
    for (int k = 1; k <= 8; k++) step();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    sw       = 4'b0000;
    test_reset();
`ifdef SWITCHES_TO_LEDS_TOGGLE_EN
    test_toggle();
`else
    test_walking_one();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
